// File: rtl/pipe_stall_ctrl_pkg.sv
// ============================================================================
// pipe_stall_ctrl_pkg : stall codes, stage bit indices and sequencer states
// Revision: 1.0
// ============================================================================
`default_nettype none

package pipe_stall_ctrl_pkg;

  localparam int unsigned STAGES = 6;

  localparam int unsigned STG_PC  = 0;
  localparam int unsigned STG_IF  = 1;
  localparam int unsigned STG_ID  = 2;
  localparam int unsigned STG_EX  = 3;
  localparam int unsigned STG_MEM = 4;
  localparam int unsigned STG_WB  = 5;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam logic [STAGES-1:0] STALL_NONE = 6'b000000;
  localparam logic [STAGES-1:0] STALL_IF   = 6'b000011;
  localparam logic [STAGES-1:0] STALL_ID   = 6'b000111;
  localparam logic [STAGES-1:0] STALL_EX   = 6'b001111;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mc_state_t;

  // A cycle count of 0 means 1, so only counts of 2 or more occupy EX beyond the start cycle.
  function automatic logic mc_multi(input logic [2:0] cycles);
    return (cycles >= 3'd2);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_stall_ctrl_if.sv
// ============================================================================
// pipe_stall_ctrl_if : stall request / stall vector bundle (STALL_PERF_EN adds counters)
// Revision: 1.0
// ============================================================================
`default_nettype none

interface pipe_stall_ctrl_if;
  logic        stallreq_from_if;
  logic        stallreq_from_id;
  logic        stallreq_from_ex;
  logic        mc_start;
  logic [2:0]  mc_cycles;
  logic        flush;
  logic [5:0]  stall;
  logic        mc_busy;
  logic        mc_done;
`ifdef STALL_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [15:0] perf_mc_ops;
`endif

  modport master (
    output stallreq_from_if, stallreq_from_id, stallreq_from_ex,
    output mc_start, mc_cycles, flush,
`ifdef STALL_PERF_EN
    input  perf_stall_cycles, perf_mc_ops,
`endif
    input  stall, mc_busy, mc_done
  );

  modport slave (
    input  stallreq_from_if, stallreq_from_id, stallreq_from_ex,
    input  mc_start, mc_cycles, flush,
`ifdef STALL_PERF_EN
    output perf_stall_cycles, perf_mc_ops,
`endif
    output stall, mc_busy, mc_done
  );
endinterface

`default_nettype wire

// File: rtl/pipe_stall_ctrl_mc_seq.sv
// ============================================================================
// mc_seq : multi-cycle EX op sequencer (IDLE/BUSY with occupancy down-counter)
// Revision: 1.0
// ============================================================================
`default_nettype none

module mc_seq
  import pipe_stall_ctrl_pkg::*;
(
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic       i_mc_start,
  input  wire logic [2:0] i_mc_cycles,
  input  wire logic       i_flush,
  output logic            o_busy,
  output logic            o_done
);

  mc_state_t  r_state;
  mc_state_t  w_state_nxt;
  logic [2:0] r_cnt;
  logic [2:0] w_cnt_nxt;
  logic       w_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = 3'd0;
        if (!i_flush && i_mc_start) begin
          if (mc_multi(i_mc_cycles)) begin
            w_state_nxt = ST_BUSY;
            w_cnt_nxt   = i_mc_cycles - 3'd1;
          end else begin
            w_done = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        // i_mc_start is deliberately not looked at here: a running op is never reloaded.
        if (i_flush) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 3'd0;
        end else if (r_cnt <= 3'd1) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 3'd0;
        end else begin
          w_cnt_nxt = r_cnt - 3'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 3'd0;
      end
    endcase
  end

  assign o_busy = (r_state == ST_BUSY);
  assign o_done = w_done & rst;

endmodule

`default_nettype wire

// File: rtl/pipe_stall_ctrl.sv
// ============================================================================
// pipe_stall_ctrl : pipeline stall priority mux; STALL_PERF_EN adds perf counters
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
(
  input  wire logic         clk,
  input  wire logic         rst,
  pipe_stall_ctrl_if.slave  bus
);

  logic              w_busy;
  logic              w_done;
  logic              w_ex_hold;
  logic [STAGES-1:0] w_stall;

  mc_seq u_mc_seq (
    .clk         (clk),
    .rst         (rst),
    .i_mc_start  (bus.mc_start),
    .i_mc_cycles (bus.mc_cycles),
    .i_flush     (bus.flush),
    .o_busy      (w_busy),
    .o_done      (w_done)
  );

  // A single-cycle op finishes in its start cycle and must not hold the pipe.
  assign w_ex_hold = bus.stallreq_from_ex | w_busy |
                     (bus.mc_start & mc_multi(bus.mc_cycles));

  always_comb begin
    w_stall = STALL_NONE;
    if (!rst || bus.flush) begin
      w_stall = STALL_NONE;
    end else if (w_ex_hold) begin
      w_stall = STALL_EX;
    end else if (bus.stallreq_from_id) begin
      w_stall = STALL_ID;
    end else if (bus.stallreq_from_if) begin
      w_stall = STALL_IF;
    end
  end

  assign bus.stall   = w_stall;
  assign bus.mc_busy = w_busy;
  assign bus.mc_done = w_done;

`ifdef STALL_PERF_EN
  logic [31:0] r_perf_stall;
  logic [15:0] r_perf_mc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_stall <= 32'd0;
      r_perf_mc    <= 16'd0;
    end else begin
      // Every non-NONE stall code holds the PC, so bit 0 alone marks a stalled cycle.
      if ((w_stall[STG_PC] == STOP) && (r_perf_stall != 32'hFFFF_FFFF)) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
      if (w_done && (r_perf_mc != 16'hFFFF)) begin
        r_perf_mc <= r_perf_mc + 16'd1;
      end
    end
  end

  assign bus.perf_stall_cycles = r_perf_stall;
  assign bus.perf_mc_ops       = r_perf_mc;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
// ============================================================================
// tb_pipe_stall_ctrl : directed self-checking bench (STALL_PERF_EN adds counter checks)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pipe_stall_ctrl;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  pipe_stall_ctrl_if bus ();

  pipe_stall_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic f_if, input logic f_id, input logic f_ex,
                       input logic st, input logic [2:0] cyc, input logic fl);
    bus.stallreq_from_if = f_if;
    bus.stallreq_from_id = f_id;
    bus.stallreq_from_ex = f_ex;
    bus.mc_start         = st;
    bus.mc_cycles        = cyc;
    bus.flush            = fl;
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [5:0] s, input logic b, input logic d);
    chk({tag, "_stall"}, {26'd0, bus.stall}, {26'd0, s});
    chk({tag, "_busy"},  {31'd0, bus.mc_busy}, {31'd0, b});
    chk({tag, "_done"},  {31'd0, bus.mc_done}, {31'd0, d});
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b0;
    drive(0, 0, 0, 0, 3'd0, 0);
    #2;
    expect_out("reset", 6'b000000, 0, 0);
    tick();
    tick();
    rst = 1'b1;

    tick(); drive(0, 1, 0, 0, 3'd0, 0); expect_out("id_only", 6'b000111, 0, 0);
    tick(); drive(1, 0, 0, 0, 3'd0, 0); expect_out("if_only", 6'b000011, 0, 0);
    tick(); drive(0, 1, 1, 0, 3'd0, 0); expect_out("id_ex",   6'b001111, 0, 0);
    tick(); drive(0, 1, 1, 0, 3'd0, 1); expect_out("flush_all", 6'b000000, 0, 0);

    // 3-cycle op
    tick(); drive(0, 0, 0, 1, 3'd3, 0); expect_out("mc3_c1", 6'b001111, 0, 0);
    tick(); drive(0, 0, 0, 0, 3'd0, 0); expect_out("mc3_c2", 6'b001111, 1, 0);
    tick(); expect_out("mc3_c3", 6'b001111, 1, 1);
    tick(); expect_out("mc3_c4", 6'b000000, 0, 0);

    // zero and one cycle ops finish in their start cycle
    tick(); drive(0, 0, 0, 1, 3'd0, 0); expect_out("mc0_c1", 6'b000000, 0, 1);
    tick(); drive(0, 0, 0, 1, 3'd1, 0); expect_out("mc1_c1", 6'b000000, 0, 1);
    tick(); drive(0, 0, 0, 0, 3'd0, 0); expect_out("mc1_c2", 6'b000000, 0, 0);

    // 5-cycle op aborted by flush in cycle 3
    tick(); drive(0, 0, 0, 1, 3'd5, 0); expect_out("mc5_c1", 6'b001111, 0, 0);
    tick(); drive(0, 0, 0, 0, 3'd0, 0); expect_out("mc5_c2", 6'b001111, 1, 0);
    tick(); drive(0, 0, 0, 0, 3'd0, 1); expect_out("mc5_c3", 6'b000000, 1, 0);
    tick(); drive(0, 0, 0, 0, 3'd0, 0); expect_out("mc5_c4", 6'b000000, 0, 0);

    // restart while busy is ignored
    tick(); drive(0, 0, 0, 1, 3'd3, 0); expect_out("rst3_c1", 6'b001111, 0, 0);
    tick(); drive(0, 0, 0, 1, 3'd7, 0); expect_out("rst3_c2", 6'b001111, 1, 0);
    tick(); drive(0, 0, 0, 0, 3'd0, 0); expect_out("rst3_c3", 6'b001111, 1, 1);
    tick(); expect_out("rst3_c4", 6'b000000, 0, 0);

    // flush together with start stays idle
    tick(); drive(0, 0, 0, 1, 3'd4, 1); expect_out("fl_st_c1", 6'b000000, 0, 0);
    tick(); drive(0, 0, 0, 0, 3'd0, 0); expect_out("fl_st_c2", 6'b000000, 0, 0);

    // reset in cycle 2 of a 4-cycle op
    tick(); drive(0, 0, 0, 1, 3'd4, 0); expect_out("rm_c1", 6'b001111, 0, 0);
    tick(); drive(0, 1, 0, 0, 3'd0, 0); expect_out("rm_c2", 6'b001111, 1, 0);
    #1;
    rst = 1'b0;
    #1;
    expect_out("rm_async", 6'b000000, 0, 0);
    tick();
    rst = 1'b1;
`ifdef STALL_PERF_EN
    #1;
    chk("perf_stall_rst", bus.perf_stall_cycles, 32'd0);
    chk("perf_mc_rst", {16'd0, bus.perf_mc_ops}, 32'd0);
    tick(); drive(0, 1, 0, 0, 3'd0, 0);
    tick();
    tick();
    tick(); drive(0, 0, 0, 0, 3'd0, 0);
    chk("perf_stall_3", bus.perf_stall_cycles, 32'd3);
`endif

    // fresh sequence after reset
    tick(); drive(0, 0, 0, 1, 3'd2, 0); expect_out("fresh_c1", 6'b001111, 0, 0);
    tick(); drive(0, 0, 0, 0, 3'd0, 0); expect_out("fresh_c2", 6'b001111, 1, 1);
    tick(); expect_out("fresh_c3", 6'b000000, 0, 0);
`ifdef STALL_PERF_EN
    chk("perf_stall_5", bus.perf_stall_cycles, 32'd5);
    chk("perf_mc_1", {16'd0, bus.perf_mc_ops}, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipe_stall_ctrl.md
PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset (clk, rst).
REQ-002 clk  input  1  pipeline clock; all state changes on its rising edge.
REQ-003 rst  input  1  asynchronous active-low reset; 0 = reset asserted.
REQ-004 stallreq_from_if  input  1  fetch stage not ready.
REQ-005 stallreq_from_id  input  1  decode hazard (load-use).
REQ-006 stallreq_from_ex  input  1  execute-stage combinational stall request.
REQ-007 mc_start  input  1  EX has a multi-cycle op (madd/msub) in its first cycle.
REQ-008 mc_cycles  input  3  total EX occupancy in cycles for that op; 0 treated as 1.
REQ-009 flush  input  1  exception or redirect; aborts any multi-cycle sequence.
REQ-010 stall  output  6  per-stage hold: bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb.
REQ-011 mc_busy  output  1  multi-cycle sequence in progress (registered).
REQ-012 mc_done  output  1  one-cycle pulse in the last cycle of a multi-cycle op.

Function
REQ-013 Stall codes SHALL be: NONE 6'b000000, IF 6'b000011, ID 6'b000111, EX 6'b001111.
REQ-014 stall SHALL be combinational from current inputs and registered state, with zero-cycle latency.
REQ-015 Priority SHALL be flush > EX (stallreq_from_ex, mc_start, or mc_busy) > ID > IF > NONE.
REQ-016 While flush=1, stall SHALL be NONE regardless of other requests.
REQ-017 FSM states SHALL be IDLE and BUSY, with a 3-bit down-counter cnt.
REQ-018 IDLE -> IDLE if mc_start=0, or if mc_start=1 and effective mc_cycles=1; mc_done=1 in that cycle when mc_start=1.
REQ-019 IDLE -> BUSY if mc_start=1 and effective N>=2; cnt loads N-1 and stall=EX in the start cycle.
REQ-020 In BUSY: stall=EX; cnt decrements each cycle; mc_done=1 and next state IDLE when cnt=1.
REQ-021 An N-cycle op SHALL produce stall=EX for exactly N-1 consecutive cycles after the start cycle; the start cycle is also EX-stalled only when N>=2.
REQ-022 mc_start asserted while BUSY SHALL be ignored, with no reload and no extension.
REQ-023 flush in any state SHALL force IDLE with cnt=0 on the next edge and suppress mc_done in the current cycle.
REQ-024 Simultaneous flush and mc_start SHALL leave the FSM in IDLE.
REQ-025 mc_busy SHALL equal (state==BUSY).

Reset
REQ-026 On rst=0 asynchronously: state=IDLE, cnt=0, mc_busy=0, and stall and mc_done evaluate to 0.
REQ-027 Reset asserted mid-sequence SHALL abort it; after deassertion the first mc_start begins a fresh sequence.

Configuration
REQ-028 Macro STALL_PERF_EN SHALL control the stall performance counters.
REQ-029 With STALL_PERF_EN defined: outputs perf_stall_cycles[31:0] and perf_mc_ops[15:0], both saturating and reset to 0.
REQ-030 perf_stall_cycles SHALL increment on each cycle where stall!=NONE; perf_mc_ops SHALL increment on each mc_done.
REQ-031 Without STALL_PERF_EN: neither port nor its logic exists, and all other behaviour is identical.

Structure
REQ-032 Stall codes, FSM state encodings, and the stage bit indices SHALL live in the shared defines include, alongside STOP/NO_STOP.
REQ-033 Counter and FSM SHALL be one sub-module, mc_seq (inputs mc_start, mc_cycles, flush; outputs busy, done); pipe_stall_ctrl holds only the priority mux and the perf counters.

Verification
REQ-034 Reset, then stallreq_from_id=1 -> stall=000111 in the same cycle; stallreq_from_if=1 alone -> 000011.
REQ-035 stallreq_from_id=1 and stallreq_from_ex=1 together -> stall=001111; add flush=1 -> 000000.
REQ-036 mc_start with mc_cycles=3 -> stall=001111 for 3 cycles total; mc_done pulses in cycle 3; mc_busy high in cycles 2-3.
REQ-037 mc_start with mc_cycles=0 and with mc_cycles=1 -> no BUSY, mc_done=1 in the start cycle, stall=000000 if no other request.
REQ-038 mc_cycles=5 with flush at cycle 3 -> stall=000000 from cycle 3, IDLE at cycle 4, no mc_done; a second mc_start during BUSY -> ignored.
REQ-039 rst pulled low at cycle 2 of a 4-cycle op -> outputs 0 immediately; with STALL_PERF_EN, perf_stall_cycles=3 after three stalled cycles.
